// File: rtl/bus_arbiter.sv
// Cycle-stealing arbiter: shares the 65C02 memory bus between the CPU and two
// bus-master requesters by stalling the core through RDY and muxing AB/DO/WE.
module bus_arbiter #(
   parameter int MAX_BURST = 16,
   parameter int CPU_MIN   = 4
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        RDY_IN,
   input  logic [15:0] CPU_AB,
   input  logic [7:0]  CPU_DO,
   input  logic        CPU_WE,
   output logic        CPU_RDY,
   input  logic [1:0]  REQ,
   output logic [1:0]  GNT,
   input  logic [31:0] DEV_AB,
   input  logic [15:0] DEV_DO,
   input  logic [1:0]  DEV_WE,
   output logic [15:0] AB,
   output logic [7:0]  DO,
   output logic        WE
);

   typedef enum logic [1:0] {
      S_CPU,
      S_STALL,
      S_DEV,
      S_RELEASE
   } state_t;

   localparam logic [7:0] BURST_LOAD = 8'(MAX_BURST);
   localparam logic [7:0] MIN_LOAD   = 8'(CPU_MIN);

   state_t      state;
   logic        owner;
   logic        last;
   logic [7:0]  burst;
   logic [7:0]  min_cnt;
   logic        next_owner;
   logic        stall;
   logic [15:0] dev_ab;
   logic [7:0]  dev_do;

   // With both requesting, the device that did not own the previous burst wins.
   assign next_owner = (REQ == 2'b11) ? ~last : REQ[1];

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state   <= S_CPU;
         owner   <= 1'b0;
         last    <= 1'b1;
         burst   <= 8'd0;
         min_cnt <= 8'd0;
         GNT     <= 2'b00;
      end else begin
         unique case (state)
            S_CPU: begin
               if (min_cnt != 8'd0)
                  min_cnt <= min_cnt - 8'd1;
               if ((|REQ) && (min_cnt == 8'd0) && !CPU_WE && RDY_IN)
                  state <= S_STALL;
            end
            S_STALL: begin
               if (REQ == 2'b00) begin
                  state <= S_RELEASE;
               end else begin
                  owner <= next_owner;
                  burst <= BURST_LOAD;
                  GNT   <= next_owner ? 2'b10 : 2'b01;
                  state <= S_DEV;
               end
            end
            S_DEV: begin
               burst <= burst - 8'd1;
               if (!REQ[owner] || (burst == 8'd1)) begin
                  last  <= owner;
                  GNT   <= 2'b00;
                  state <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               min_cnt <= MIN_LOAD;
               state   <= S_CPU;
            end
            default: state <= S_CPU;
         endcase
      end
   end

   assign stall   = (state != S_CPU);
   assign CPU_RDY = RDY_IN & ~stall;
   assign dev_ab  = owner ? DEV_AB[31:16] : DEV_AB[15:0];
   assign dev_do  = owner ? DEV_DO[15:8]  : DEV_DO[7:0];

   // The CPU cycle repeats while stalled, so its write must not hit memory then.
   always_comb begin
      AB = CPU_AB;
      DO = CPU_DO;
      WE = CPU_WE;
      unique case (state)
         S_DEV: begin
            AB = dev_ab;
            DO = dev_do;
            WE = DEV_WE[owner] & REQ[owner];
         end
         S_STALL, S_RELEASE: WE = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, fairness and
// reset sequences, then random traffic against a behavioural model.
module tb_bus_arbiter;

   localparam int MB_A = 4;
   localparam int CM_A = 4;
   localparam int MB_B = 1;
   localparam int CM_B = 0;

   localparam int P_CPU = 0;
   localparam int P_STALL = 1;
   localparam int P_DEV = 2;
   localparam int P_REL = 3;

   logic        clk = 1'b0;
   logic        RST;
   logic        RDY_IN;
   logic [15:0] CPU_AB;
   logic [7:0]  CPU_DO;
   logic        CPU_WE;
   logic [1:0]  REQ;
   logic [31:0] DEV_AB;
   logic [15:0] DEV_DO;
   logic [1:0]  DEV_WE;

   logic        cpu_rdy [2];
   logic [1:0]  gnt [2];
   logic [15:0] ab [2];
   logic [7:0]  dout [2];
   logic        we [2];

   int checks = 0;
   int failures = 0;

   int mb [2] = '{MB_A, MB_B};
   int cm [2] = '{CM_A, CM_B};
   int m_phase [2];
   int m_owner [2];
   int m_last [2];
   int m_used [2];
   int m_cool [2];

   typedef struct {
      logic [1:0]  req;
      logic        cwe;
      logic [15:0] cab;
      logic [1:0]  gnt;
      logic        rdy;
      logic [15:0] ab;
      logic [7:0]  dout;
      logic        we;
   } vec_t;

   vec_t vecs [26];

   bus_arbiter #(.MAX_BURST(MB_A), .CPU_MIN(CM_A)) dut_a (
      .clk(clk), .RST(RST), .RDY_IN(RDY_IN),
      .CPU_AB(CPU_AB), .CPU_DO(CPU_DO), .CPU_WE(CPU_WE), .CPU_RDY(cpu_rdy[0]),
      .REQ(REQ), .GNT(gnt[0]),
      .DEV_AB(DEV_AB), .DEV_DO(DEV_DO), .DEV_WE(DEV_WE),
      .AB(ab[0]), .DO(dout[0]), .WE(we[0])
   );

   bus_arbiter #(.MAX_BURST(MB_B), .CPU_MIN(CM_B)) dut_b (
      .clk(clk), .RST(RST), .RDY_IN(RDY_IN),
      .CPU_AB(CPU_AB), .CPU_DO(CPU_DO), .CPU_WE(CPU_WE), .CPU_RDY(cpu_rdy[1]),
      .REQ(REQ), .GNT(gnt[1]),
      .DEV_AB(DEV_AB), .DEV_DO(DEV_DO), .DEV_WE(DEV_WE),
      .AB(ab[1]), .DO(dout[1]), .WE(we[1])
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic [1:0] r, logic w, logic [15:0] a, logic [1:0] g,
                               logic rdy, logic [15:0] eab, logic [7:0] edo, logic ewe);
      vec_t v;
      v.req = r; v.cwe = w; v.cab = a; v.gnt = g;
      v.rdy = rdy; v.ab = eab; v.dout = edo; v.we = ewe;
      return v;
   endfunction

   task automatic checkField(input string name, input int d, input logic [31:0] act,
                             input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, d, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         m_phase[d] = P_CPU;
         m_owner[d] = 0;
         m_last[d]  = 1;
         m_used[d]  = 0;
         m_cool[d]  = 0;
      end
   endtask

   task automatic modelExpect(input int d, output logic [1:0] g, output logic r,
                              output logic [15:0] a, output logic [7:0] o, output logic w);
      int sel;
      sel = m_owner[d];
      g = 2'b00;
      r = RDY_IN && (m_phase[d] == P_CPU);
      a = CPU_AB;
      o = CPU_DO;
      w = (m_phase[d] == P_CPU) ? CPU_WE : 1'b0;
      if (m_phase[d] == P_DEV) begin
         g = 2'(1 << sel);
         a = DEV_AB[sel*16 +: 16];
         o = DEV_DO[sel*8 +: 8];
         w = DEV_WE[sel] && REQ[sel];
      end
   endtask

   task automatic modelStep();
      bit go;
      for (int d = 0; d < 2; d++) begin
         case (m_phase[d])
            P_CPU: begin
               go = (REQ != 2'b00) && (m_cool[d] == 0) && !CPU_WE && RDY_IN;
               if (m_cool[d] > 0) m_cool[d]--;
               if (go) m_phase[d] = P_STALL;
            end
            P_STALL: begin
               if (REQ == 2'b00) begin
                  m_phase[d] = P_REL;
               end else begin
                  m_owner[d] = (REQ == 2'b11) ? 1 - m_last[d] : (REQ == 2'b10 ? 1 : 0);
                  m_used[d]  = 0;
                  m_phase[d] = P_DEV;
               end
            end
            P_DEV: begin
               m_used[d]++;
               if (!REQ[m_owner[d]] || m_used[d] == mb[d]) begin
                  m_last[d]  = m_owner[d];
                  m_phase[d] = P_REL;
               end
            end
            default: begin
               m_cool[d]  = cm[d];
               m_phase[d] = P_CPU;
            end
         endcase
      end
   endtask

   task automatic applyStimulus(input logic [1:0] r, input logic w, input logic [15:0] a,
                                input logic rdy);
      @(negedge clk);
      REQ = r;
      CPU_WE = w;
      CPU_AB = a;
      RDY_IN = rdy;
      #2;
   endtask

   task automatic checkOutput();
      logic [1:0]  eg;
      logic        er;
      logic [15:0] ea;
      logic [7:0]  eo;
      logic        ew;
      for (int d = 0; d < 2; d++) begin
         modelExpect(d, eg, er, ea, eo, ew);
         checkField("gnt", d, gnt[d], eg);
         checkField("cpu_rdy", d, cpu_rdy[d], er);
         checkField("ab", d, ab[d], ea);
         checkField("do", d, dout[d], eo);
         checkField("we", d, we[d], ew);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (RST) modelStep();
   endtask

   initial begin
      int hist [$];
      int rv [$];
      int rl [$];
      int rs [$];
      int first;
      bit found;

      RST = 1'b0; RDY_IN = 1'b1; REQ = 2'b00;
      CPU_AB = 16'h1234; CPU_DO = 8'h5A; CPU_WE = 1'b0;
      DEV_AB = {16'h0200, 16'h8000}; DEV_DO = {8'hA5, 8'h3C}; DEV_WE = 2'b10;
      modelReset();

      // Reset state with REQ active: no grant, bus owned by the CPU
      applyStimulus(2'b11, 1'b1, 16'h1111, 1'b1);
      checkField("rst_gnt", 0, gnt[0], 2'b00);
      checkField("rst_rdy", 0, cpu_rdy[0], 1'b1);
      checkField("rst_we", 0, we[0], 1'b1);
      checkOutput();
      @(posedge clk);
      #2 RST = 1'b1;

      vecs[0]  = mk(2'b01, 0, 16'h1234, 2'b00, 1, 16'h1234, 8'h5A, 0);
      vecs[1]  = mk(2'b01, 0, 16'h1234, 2'b00, 0, 16'h1234, 8'h5A, 0);
      vecs[2]  = mk(2'b01, 0, 16'h1234, 2'b01, 0, 16'h8000, 8'h3C, 0);
      vecs[3]  = mk(2'b01, 0, 16'h1234, 2'b01, 0, 16'h8000, 8'h3C, 0);
      vecs[4]  = mk(2'b00, 0, 16'h1234, 2'b01, 0, 16'h8000, 8'h3C, 0);
      vecs[5]  = mk(2'b00, 0, 16'h1234, 2'b00, 0, 16'h1234, 8'h5A, 0);
      for (int i = 6; i < 10; i++)
         vecs[i] = mk(2'b00, 0, 16'h1234, 2'b00, 1, 16'h1234, 8'h5A, 0);
      vecs[10] = mk(2'b01, 1, 16'h4444, 2'b00, 1, 16'h4444, 8'h5A, 1);
      vecs[11] = mk(2'b01, 1, 16'h4444, 2'b00, 1, 16'h4444, 8'h5A, 1);
      vecs[12] = mk(2'b01, 0, 16'h1234, 2'b00, 1, 16'h1234, 8'h5A, 0);
      vecs[13] = mk(2'b00, 0, 16'h1234, 2'b00, 0, 16'h1234, 8'h5A, 0);
      vecs[14] = mk(2'b00, 0, 16'h1234, 2'b00, 0, 16'h1234, 8'h5A, 0);
      for (int i = 15; i < 19; i++)
         vecs[i] = mk(2'b00, 0, 16'h1234, 2'b00, 1, 16'h1234, 8'h5A, 0);
      vecs[19] = mk(2'b10, 0, 16'h1234, 2'b00, 1, 16'h1234, 8'h5A, 0);
      vecs[20] = mk(2'b10, 0, 16'h1234, 2'b00, 0, 16'h1234, 8'h5A, 0);
      vecs[21] = mk(2'b10, 0, 16'h1234, 2'b10, 0, 16'h0200, 8'hA5, 1);
      vecs[22] = mk(2'b10, 0, 16'h1234, 2'b10, 0, 16'h0200, 8'hA5, 1);
      vecs[23] = mk(2'b00, 0, 16'h1234, 2'b10, 0, 16'h0200, 8'hA5, 0);
      vecs[24] = mk(2'b00, 0, 16'h1234, 2'b00, 0, 16'h1234, 8'h5A, 0);
      vecs[25] = mk(2'b00, 0, 16'h1234, 2'b00, 1, 16'h1234, 8'h5A, 0);

      for (int i = 0; i < 26; i++) begin
         applyStimulus(vecs[i].req, vecs[i].cwe, vecs[i].cab, 1'b1);
         checkField($sformatf("vec%0d_gnt", i), 0, gnt[0], vecs[i].gnt);
         checkField($sformatf("vec%0d_rdy", i), 0, cpu_rdy[0], vecs[i].rdy);
         checkField($sformatf("vec%0d_ab", i), 0, ab[0], vecs[i].ab);
         checkField($sformatf("vec%0d_do", i), 0, dout[0], vecs[i].dout);
         checkField($sformatf("vec%0d_we", i), 0, we[0], vecs[i].we);
         checkOutput();
         advance();
      end

      // Fairness with both requesters held: runs of 4, alternating, with a CPU gap
      for (int i = 0; i < 40; i++) begin
         applyStimulus(2'b11, 1'b0, 16'h1234, 1'b1);
         checkOutput();
         hist.push_back(int'(gnt[0]));
         advance();
      end
      for (int i = 0; i < hist.size(); i++) begin
         if (hist[i] != 0) begin
            if (i > 0 && hist[i-1] == hist[i]) begin
               rl[rl.size()-1]++;
            end else begin
               rv.push_back(hist[i]);
               rl.push_back(1);
               rs.push_back(i);
            end
         end
      end
      checkField("fair_runs_ge3", 0, rv.size() >= 3, 1);
      if (rv.size() >= 3) begin
         checkField("run0_gnt", 0, rv[0], 1);
         checkField("run1_gnt", 0, rv[1], 2);
         checkField("run2_gnt", 0, rv[2], 1);
         for (int k = 0; k < 3; k++)
            checkField($sformatf("run%0d_len", k), 0, rl[k], 4);
         for (int k = 0; k < 2; k++)
            checkField($sformatf("gap%0d_ge6", k), 0, (rs[k+1] - rs[k] - rl[k]) >= 6, 1);
      end

      // Asynchronous reset on the third device cycle of a burst
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         applyStimulus(2'b11, 1'b0, 16'h1234, 1'b1);
         checkOutput();
         if (m_phase[0] == P_DEV && m_used[0] == 2) found = 1;
         else advance();
      end
      checkField("reach_burst2", 0, found, 1);
      CPU_WE = 1'b1;
      CPU_AB = 16'h7777;
      #1 RST = 1'b0;
      #1;
      modelReset();
      checkField("midrst_gnt", 0, gnt[0], 2'b00);
      checkField("midrst_ab", 0, ab[0], 16'h7777);
      checkField("midrst_we", 0, we[0], 1'b1);
      checkField("midrst_rdy", 0, cpu_rdy[0], 1'b1);
      checkOutput();
      @(posedge clk);
      #2 RST = 1'b1;
      first = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(2'b11, 1'b0, 16'h1234, 1'b1);
         checkOutput();
         if (first == 0 && gnt[0] != 2'b00) first = int'(gnt[0]);
         advance();
      end
      checkField("first_grant_after_reset", 0, first, 1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         DEV_AB = $urandom;
         DEV_DO = 16'($urandom);
         DEV_WE = 2'($urandom_range(0, 3));
         CPU_DO = 8'($urandom);
         applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                       16'($urandom), ($urandom_range(0, 7) != 0));
         checkOutput();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the 65C02 core's single memory bus between the CPU and two bus-master requesters, e.g. a DMA channel and a video fetch unit.
- Steals cycles by pulling the core's RDY low, then muxes the granted requester's AB/DO/WE onto the memory bus for a bounded burst.
- Hands the bus back with a one-cycle turnaround.
- Sits between cpu, the requesters and memory. Read data (DB) is broadcast to all masters and is not muxed.

Parameters:
- MAX_BURST, 16, maximum consecutive device cycles per grant (1..255).
- CPU_MIN, 4, minimum CPU-owned cycles after a release before the next steal (0..255).

Ports:
- clk  in  1  clock
- RST  in  1  asynchronous active-low reset
- RDY_IN  in  1  external ready (slow memory); passed through to the CPU
- CPU_AB  in  16  CPU address
- CPU_DO  in  8  CPU write data
- CPU_WE  in  1  CPU write enable
- CPU_RDY  out  1  ready to core: RDY_IN & ~stall
- REQ  in  2  per-requester bus request (level)
- GNT  out  2  per-requester grant, one-hot or zero
- DEV_AB  in  32  {dev1, dev0} addresses
- DEV_DO  in  16  {dev1, dev0} write data
- DEV_WE  in  2  per-requester write enable
- AB  out  16  memory address
- DO  out  8  memory write data
- WE  out  1  memory write enable

Behaviour:
- States: CPU, STALL, DEV, RELEASE. Registered: state, owner (1 bit), last (1 bit), burst counter (8 bit), min counter (8 bit).
- Reset (RST=0, async): state=CPU, GNT=00, owner=0, last=1, burst=0, min=0. stall=0, so CPU_RDY=RDY_IN. AB/DO/WE follow the CPU.
- Bus mux (combinational):
  - DEV: AB/DO/WE = selected device.
  - All other states: AB/DO/WE = CPU.
  - WE is forced 0 in STALL and RELEASE, because the CPU cycle repeats while RDY is low.
- CPU state:
  - stall=0; min decrements toward 0 each cycle.
  - Go to STALL when all of: |REQ, min==0, CPU_WE==0, RDY_IN==1. A steal never starts on a CPU write cycle.
- STALL (1 cycle):
  - stall=1.
  - Pick owner round-robin: if both REQ bits are set, owner = ~last; otherwise owner = the requesting bit.
  - If REQ drops to 00 during STALL, go to RELEASE with no grant.
  - Otherwise go to DEV and load burst=MAX_BURST.
- DEV:
  - stall=1, GNT[owner]=1. Each GNT cycle is exactly one device access; the device samples DB at the end of the cycle. burst decrements each cycle.
  - Leave to RELEASE after the cycle in which REQ[owner]==0 is seen (that cycle performs no access: WE forced 0) or burst reaches 1.
  - On exit: last<=owner, GNT returns to 00.
  - The other requester never preempts mid-burst.
- RELEASE (1 cycle):
  - stall=1, CPU address re-presented.
  - Next state is CPU; load min=CPU_MIN.
  - CPU_RDY rises the cycle after RELEASE (if RDY_IN=1).
- Latency:
  - REQ rise sampled in CPU state → GNT high 2 cycles later (STALL, then DEV).
  - Steal overhead = 2 CPU cycles plus the burst length.
- RDY_IN=0 in DEV/STALL/RELEASE: ignored by the arbiter; CPU_RDY is 0 regardless. Devices are assumed to use single-cycle memory.
- MAX_BURST=1: exactly one device cycle per grant. CPU_MIN=0: back-to-back steals are allowed, with RELEASE→CPU→STALL costing at least 1 CPU cycle.
- Reset mid-burst: GNT drops immediately and asynchronously, the bus reverts to the CPU, and CPU_RDY=RDY_IN.

Test Plan:
- Single request: REQ=01 while CPU reads 0x1234 with CPU_WE=0, DEV_AB0=0x8000, held for 3 cycles. Required: CPU_RDY low for 5 cycles; GNT=01 for 3 cycles with AB=0x8000; RELEASE AB=0x1234; then CPU_RDY=1.
- Write protection: REQ=01 asserted on a cycle with CPU_WE=1. Required: STALL entered only on the first following cycle with CPU_WE=0; the CPU write reaches memory untouched.
- Burst limit and fairness, MAX_BURST=4, CPU_MIN=4, REQ=11 held: GNT sequence 01×4, then ≥4+2 cycles of CPU ownership, then 10×4, then 01×4. No two consecutive grants go to the same device.
- Request withdrawn in STALL: REQ=01 pulsed for 1 cycle. Required: STALL→RELEASE; GNT never asserted; WE=0 throughout; CPU_RDY low exactly 2 cycles.
- Device write: dev1 with DEV_WE=1, DEV_DO=0xA5, DEV_AB=0x0200. Required: WE=1, DO=0xA5, AB=0x0200 only during GNT=10; WE=0 in STALL and RELEASE.
- Async reset mid-burst at burst=2: GNT=00, WE=CPU_WE and AB=CPU_AB immediately; after release, REQ=11 grants dev0 first (last=1).
